regbank_periodic: RTL

Parametrised multi-channel register bank with built-in strobe divider and programmable periodic auto-clear, all on a single clock. Each channel independently holds, loads every cycle, loads on the divided strobe, or loads with periodic clear. Sits between input ports and downstream logic as the generalised replacement for fixed 3×4-bit register blocks with a hard-wired counter reset and a derived clock. Derived clocks are replaced by clock enables.

---
 rtl/regbank_periodic.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/regbank_periodic.sv
// ============================================================================
// regbank_periodic
// ----------------------------------------------------------------------------
// Multi-channel register bank with a built-in strobe divider and a
// programmable periodic auto-clear. Everything runs on the single clock
// `clk`; the divided "clock" of older fixed designs is replaced by the
// clock-enable style strobe `stb`.
//
// Each channel k (data d[k*WIDTH +: WIDTH], mode mode[2k +: 2]) updates at
// every rising edge according to its mode:
//   00 : hold
//   01 : load d every edge
//   10 : load d only at edges where stb = 1
//   11 : load d, or load 0 at edges where clr = 1
// Reset has priority over clear, which has priority over load.
//
// Parameters
//   WIDTH    bits per channel
//   CHANNELS number of channels (>= 1)
//   DIV      strobe divide ratio (>= 1)
//   CNT_W    period counter width
//
// Ports
//   clk       in   sole clock, rising edge
//   rst       in   synchronous active-high reset
//   d         in   channel data, CHANNELS*WIDTH
//   mode      in   per-channel mode, 2*CHANNELS
//   period    in   auto-clear period minus one
//   q         out  channel registers, CHANNELS*WIDTH
//   stb       out  divided strobe (high every DIV-th cycle)
//   clr       out  period-wrap indicator
//   snap      out  snapshot of q taken at each wrap   (REGBANK_SNAPSHOT_EN)
//   snap_vld  out  one-cycle pulse after each snapshot (REGBANK_SNAPSHOT_EN)
//
// Configuration macro: REGBANK_SNAPSHOT_EN adds the snapshot registers and
// the snap / snap_vld ports. Without it neither the ports nor the registers
// exist.
// ============================================================================
module regbank_periodic #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 3,
    parameter int DIV      = 2,
    parameter int CNT_W    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CHANNELS*WIDTH-1:0]    d,
    input  logic [2*CHANNELS-1:0]        mode,
    input  logic [CNT_W-1:0]             period,
    output logic [CHANNELS*WIDTH-1:0]    q,
    output logic                         stb,
`ifdef REGBANK_SNAPSHOT_EN
    output logic [CHANNELS*WIDTH-1:0]    snap,
    output logic                         snap_vld,
`endif
    output logic                         clr
);

    // Divider counter is at least one bit wide so DIV = 1 stays legal.
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_LOAD  = 2'b01;
    localparam logic [1:0] MODE_STB   = 2'b10;
    localparam logic [1:0] MODE_CLEAR = 2'b11;

    // ------------------------------------------------------------------------
    // Strobe divider
    // ------------------------------------------------------------------------
    logic [DIV_W-1:0] div_cnt_q;
    logic [DIV_W-1:0] div_cnt_d;

    // For DIV = 1 the counter sits at 0 == DIV_LAST, so stb is constantly 1.
    assign stb = (div_cnt_q == DIV_LAST);

    always_comb begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
        if (stb) begin
            div_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Period counter
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0] per_cnt_q;
    logic [CNT_W-1:0] per_cnt_d;

    // ">=" rather than "==": if period is lowered below the current count the
    // counter wraps on the next edge instead of running all the way round.
    assign clr = (per_cnt_q >= period);

    always_comb begin
        per_cnt_d = per_cnt_q + CNT_W'(1);
        if (clr) begin
            per_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            per_cnt_q <= '0;
        end else begin
            per_cnt_q <= per_cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Channel registers
    // ------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            logic [WIDTH-1:0] ch_q;
            logic [WIDTH-1:0] ch_d;
            logic [1:0]       ch_mode;
            logic [WIDTH-1:0] ch_in;

            assign ch_mode = mode[2*gi +: 2];
            assign ch_in   = d[gi*WIDTH +: WIDTH];

            always_comb begin
                ch_d = ch_q;
                unique case (ch_mode)
                    MODE_HOLD:  ch_d = ch_q;
                    MODE_LOAD:  ch_d = ch_in;
                    MODE_STB:   ch_d = stb ? ch_in : ch_q;
                    MODE_CLEAR: ch_d = clr ? '0 : ch_in;
                    default:    ch_d = ch_q;
                endcase
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    ch_q <= '0;
                end else begin
                    ch_q <= ch_d;
                end
            end

            assign q[gi*WIDTH +: WIDTH] = ch_q;
        end
    endgenerate

`ifdef REGBANK_SNAPSHOT_EN
    // ------------------------------------------------------------------------
    // Snapshot: captures the pre-update q at every wrap edge.
    // ------------------------------------------------------------------------
    logic [CHANNELS*WIDTH-1:0] snap_q;
    logic                      snap_vld_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            snap_q     <= '0;
            snap_vld_q <= 1'b0;
        end else begin
            snap_vld_q <= clr;
            if (clr) begin
                snap_q <= q;
            end
        end
    end

    assign snap     = snap_q;
    assign snap_vld = snap_vld_q;
`endif

endmodule
